// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch stage: fetch FSM state
// encoding, the bubble instruction word and the default reset fetch address.
// -----------------------------------------------------------------------------
package mips_pkg;

    // IDLE : one cycle after reset release, no request
    // REQ  : request outstanding at the current fetch PC
    // HOLD : fetched word parked in the one-entry buffer, no request
    // DROP : request to a stale address still outstanding; its data is discarded
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Load bus from the fetch control logic into the IF/ID pipeline register.
//   stall    : hold IF/ID contents
//   load     : a fetched word is accepted this cycle
//   instr    : accepted instruction word
//   pc_plus4 : address following the accepted instruction
// master = fetch control (drives), slave = IF/ID register (receives).
// -----------------------------------------------------------------------------
interface if_stage_if;
    logic        stall;
    logic        load;
    logic [31:0] instr;
    logic [31:0] pc_plus4;

    modport master (output stall, output load, output instr, output pc_plus4);
    modport slave  (input  stall, input  load, input  instr, input  pc_plus4);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with three behaviours:
//   stall         -> hold
//   load          -> capture {instr, pc_plus4, valid=1}
//   neither       -> bubble: instr=NOP, valid=0, pc_plus4 unchanged
// Ports: clk, rst_n (async, active-low), bus (if_stage_if.slave),
//        instr, pc_plus4, valid (registered outputs).
// -----------------------------------------------------------------------------
module if_id_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    if_stage_if.slave         bus,
    output logic [31:0]       instr,
    output logic [31:0]       pc_plus4,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP;
            pc_plus4 <= 32'h0;
            valid    <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.load) begin
                instr    <= bus.instr;
                pc_plus4 <= bus.pc_plus4;
                valid    <= 1'b1;
            end else begin
                instr    <= NOP;
                valid    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: fetch PC, imem request FSM, one-entry word buffer
// and redirect handling; feeds the IF/ID register (if_id_reg).
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_stallF, i_stallD             hazard-unit stalls for PC and IF/ID
//   i_pc_srcD, i_pc_branchD        taken branch and its target
//   i_jumpD, i_pc_jumpD            jump and its target
//   o_imem_req, o_imem_addr        instruction memory request
//   i_imem_ack, i_imem_rdata       one-cycle data-valid pulse and word
//   o_pcF                          current fetch PC
//   o_instrD, o_pc_plus4D, o_validD  IF/ID register contents
// -----------------------------------------------------------------------------
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stallF,
    input  logic        i_stallD,
    input  logic        i_pc_srcD,
    input  logic [31:0] i_pc_branchD,
    input  logic        i_jumpD,
    input  logic [31:0] i_pc_jumpD,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pcF,
    output logic [31:0] o_instrD,
    output logic [31:0] o_pc_plus4D,
    output logic        o_validD
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  word_buf;
    logic [31:0]  stale_addr;
    logic         req;

    logic         redirect;
    logic [31:0]  target;
    logic         word_avail;
    logic [31:0]  word;
    logic         accept;
    logic [31:0]  pc_plus4;

    if_stage_if ifid_bus ();

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        redirect   = (i_pc_srcD | i_jumpD) & ~i_stallD;
        target     = i_pc_srcD ? i_pc_branchD : i_pc_jumpD;
        word_avail = ((state == S_REQ) & i_imem_ack) | (state == S_HOLD);
        word       = (state == S_HOLD) ? word_buf : i_imem_rdata;
        accept     = word_avail & ~i_stallF & ~i_stallD & ~redirect;
        pc_plus4   = pc + 32'd4;  // wraps modulo 2^32
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the word buffer and stale address are single registers, not a
    // memory array, so they are reset along with the rest of the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            req        <= 1'b0;
            pc         <= RESET_PC;
            word_buf   <= NOP;
            stale_addr <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Any ack seen here belongs to a transaction abandoned by reset.
                    if (redirect) pc <= target;
                    state <= S_REQ;
                    req   <= 1'b1;
                end
                S_REQ: begin
                    if (redirect) begin
                        pc <= target;
                        if (!i_imem_ack) begin
                            // Request stays on the bus at the old address.
                            state      <= S_DROP;
                            stale_addr <= pc;
                        end
                    end else if (i_imem_ack) begin
                        if (accept) begin
                            pc <= pc_plus4;
                        end else begin
                            word_buf <= i_imem_rdata;
                            state    <= S_HOLD;
                            req      <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc       <= target;
                        word_buf <= NOP;
                        state    <= S_REQ;
                        req      <= 1'b1;
                    end else if (accept) begin
                        pc    <= pc_plus4;
                        state <= S_REQ;
                        req   <= 1'b1;
                    end
                end
                S_DROP: begin
                    // Later redirects only retarget the PC; the stale ack must
                    // still be absorbed before fetching resumes.
                    if (redirect)   pc    <= target;
                    if (i_imem_ack) state <= S_REQ;
                end
                default: begin
                    state <= S_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = (state == S_DROP) ? stale_addr : pc;
    assign o_pcF       = pc;

    assign ifid_bus.stall    = i_stallD;
    assign ifid_bus.load     = accept;
    assign ifid_bus.instr    = word;
    assign ifid_bus.pc_plus4 = pc_plus4;

    if_id_reg u_if_id_reg (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .bus      (ifid_bus.slave),
        .instr    (o_instrD),
        .pc_plus4 (o_pc_plus4D),
        .valid    (o_validD)
    );

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. Inputs change 1 ns after a rising edge and
// outputs are sampled there too; imem is modelled by the bench driving ack
// and rdata for the cycle that follows.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stallF, stallD;
    logic        pc_srcD, jumpD;
    logic [31:0] pc_branchD, pc_jumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pcF, instrD, pc_plus4D;
    logic        validD;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stallF     (stallF),
        .i_stallD     (stallD),
        .i_pc_srcD    (pc_srcD),
        .i_pc_branchD (pc_branchD),
        .i_jumpD      (jumpD),
        .i_pc_jumpD   (pc_jumpD),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .o_pcF        (pcF),
        .o_instrD     (instrD),
        .o_pc_plus4D  (pc_plus4D),
        .o_validD     (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the bench memory returns for a given address.
    function automatic logic [31:0] wd(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pcF); end
        checks++; if (instrD !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instrD); end
        checks++; if (pc_plus4D !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", pc_plus4D); end
        checks++; if (validD !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", validD); end
    endtask

    task automatic test_zero_wait();
        rst_n = 1'b1;           // ack still high: must be ignored in IDLE
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL zw_req0 got %b/%h want 1/0", imem_req, imem_addr); end
        checks++; if (validD !== 1'b0) begin errors++; $display("FAIL zw_valid0 got %b want 0", validD); end
        imem_ack = 1'b1; imem_rdata = wd(32'h0);
        step();
        checks++; if (imem_addr !== 32'h4 || pcF !== 32'h4) begin errors++; $display("FAIL zw_addr4 got %h/%h want 4", imem_addr, pcF); end
        checks++; if (instrD !== wd(32'h0) || pc_plus4D !== 32'h4 || validD !== 1'b1) begin errors++; $display("FAIL zw_ifid0 got %h/%h/%b want %h/4/1", instrD, pc_plus4D, validD, wd(32'h0)); end
        imem_rdata = wd(32'h4);
        step();
        checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL zw_addr8 got %h/%b want 8/1", imem_addr, imem_req); end
        checks++; if (instrD !== wd(32'h4) || pc_plus4D !== 32'h8) begin errors++; $display("FAIL zw_ifid4 got %h/%h want %h/8", instrD, pc_plus4D, wd(32'h4)); end
    endtask

    task automatic test_stall_hold();
        imem_rdata = wd(32'h8); stallF = 1'b1; stallD = 1'b1;
        step();
        imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
        checks++; if (imem_req !== 1'b0 || pcF !== 32'h8) begin errors++; $display("FAIL hold_req got %b/%h want 0/8", imem_req, pcF); end
        checks++; if (instrD !== wd(32'h4) || validD !== 1'b1) begin errors++; $display("FAIL hold_frz got %h/%b want %h/1", instrD, validD, wd(32'h4)); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (imem_req !== 1'b0 || instrD !== wd(32'h4) || pc_plus4D !== 32'h8) begin errors++; $display("FAIL hold_cyc%0d got %b/%h/%h", i, imem_req, instrD, pc_plus4D); end
        end
        stallF = 1'b0; stallD = 1'b0;
        step();
        checks++; if (instrD !== wd(32'h8) || pc_plus4D !== 32'hC || validD !== 1'b1) begin errors++; $display("FAIL hold_rel got %h/%h/%b want %h/c/1", instrD, pc_plus4D, validD, wd(32'h8)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL hold_next got %b/%h want 1/c", imem_req, imem_addr); end
    endtask

    task automatic test_stallf_only();
        imem_ack = 1'b1; imem_rdata = wd(32'hC); stallF = 1'b1;
        step();
        imem_ack = 1'b0; stallF = 1'b0;
        checks++; if (instrD !== 32'h0 || pc_plus4D !== 32'hC || validD !== 1'b0) begin errors++; $display("FAIL sf_bubble got %h/%h/%b want 0/c/0", instrD, pc_plus4D, validD); end
        checks++; if (pcF !== 32'hC || imem_req !== 1'b0) begin errors++; $display("FAIL sf_pc got %h/%b want c/0", pcF, imem_req); end
        step();
        checks++; if (instrD !== wd(32'hC) || pc_plus4D !== 32'h10 || imem_addr !== 32'h10) begin errors++; $display("FAIL sf_acc got %h/%h/%h", instrD, pc_plus4D, imem_addr); end
    endtask

    task automatic test_branch_drop();
        pc_srcD = 1'b1; pc_branchD = 32'h40;
        step();
        pc_srcD = 1'b0;
        checks++; if (pcF !== 32'h40 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL drop_ent got %h/%h/%b want 40/10/1", pcF, imem_addr, imem_req); end
        checks++; if (validD !== 1'b0 || instrD !== 32'h0 || pc_plus4D !== 32'h10) begin errors++; $display("FAIL drop_bub got %b/%h/%h want 0/0/10", validD, instrD, pc_plus4D); end
        step();
        checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL drop_wait got %h/%b want 10/1", imem_addr, imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1 || validD !== 1'b0 || instrD !== 32'h0) begin errors++; $display("FAIL drop_disc got %h/%b/%b/%h", imem_addr, imem_req, validD, instrD); end
        imem_rdata = wd(32'h40);
        step();
        imem_ack = 1'b0;
        checks++; if (instrD !== wd(32'h40) || pc_plus4D !== 32'h44 || validD !== 1'b1 || pcF !== 32'h44) begin errors++; $display("FAIL drop_tgt got %h/%h/%b/%h", instrD, pc_plus4D, validD, pcF); end
    endtask

    task automatic test_dual_redirect();
        pc_srcD = 1'b1; jumpD = 1'b1; pc_branchD = 32'h80; pc_jumpD = 32'hC0; stallD = 1'b1;
        step();
        checks++; if (pcF !== 32'h44 || validD !== 1'b1 || imem_addr !== 32'h44) begin errors++; $display("FAIL dual_stall got %h/%b/%h want 44/1/44", pcF, validD, imem_addr); end
        stallD = 1'b0;
        step();
        checks++; if (pcF !== 32'h80 || validD !== 1'b0 || imem_addr !== 32'h44 || imem_req !== 1'b1) begin errors++; $display("FAIL dual_take got %h/%b/%h/%b want 80/0/44/1", pcF, validD, imem_addr, imem_req); end
        pc_srcD = 1'b0;
        step();
        jumpD = 1'b0;
        checks++; if (pcF !== 32'hC0 || imem_addr !== 32'h44) begin errors++; $display("FAIL drop_2nd got %h/%h want c0/44", pcF, imem_addr); end
    endtask

    task automatic test_reset_in_drop();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pcF !== 32'h0) begin errors++; $display("FAIL rd_async got %b/%h/%h want 0/0/0", imem_req, imem_addr, pcF); end
        checks++; if (instrD !== 32'h0 || pc_plus4D !== 32'h0 || validD !== 1'b0) begin errors++; $display("FAIL rd_ifid got %h/%h/%b want 0/0/0", instrD, pc_plus4D, validD); end
        imem_ack = 1'b1; imem_rdata = 32'hFACE_FACE;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pcF !== 32'h0 || validD !== 1'b0) begin errors++; $display("FAIL rd_stray got %b/%h/%h/%b want 1/0/0/0", imem_req, imem_addr, pcF, validD); end
        imem_rdata = wd(32'h0);
        step();
        imem_ack = 1'b0;
        checks++; if (pcF !== 32'h4 || instrD !== wd(32'h0) || validD !== 1'b1) begin errors++; $display("FAIL rd_restart got %h/%h/%b", pcF, instrD, validD); end
    endtask

    task automatic test_wrap();
        jumpD = 1'b1; pc_jumpD = 32'hFFFF_FFFC;
        step();
        jumpD = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        step();
        checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr got %h/%b want fffffffc/1", imem_addr, imem_req); end
        imem_rdata = wd(32'hFFFF_FFFC);
        step();
        imem_ack = 1'b0;
        checks++; if (pc_plus4D !== 32'h0 || pcF !== 32'h0 || instrD !== wd(32'hFFFF_FFFC) || validD !== 1'b1) begin errors++; $display("FAIL wrap_pc4 got %h/%h/%h/%b", pc_plus4D, pcF, instrD, validD); end
    endtask

    initial begin
        rst_n = 1'b0; stallF = 1'b0; stallD = 1'b0;
        pc_srcD = 1'b0; jumpD = 1'b0; pc_branchD = 32'h0; pc_jumpD = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall_hold();
        test_stallf_only();
        test_branch_drop();
        test_dual_redirect();
        test_reset_in_drop();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
